// File: rtl/dtw_band_core.sv
// dtw_band_core: banded (Sakoe-Chiba) DTW distance engine.
// Query samples stream in one per row; template samples are read from an
// external single-port SRAM once per column. The cost matrix is evaluated
// row by row through a single in-place row buffer.
module dtw_band_core #(
  parameter int DW  = 8,
  parameter int LEN = 32,
  parameter int AW  = 10,
  parameter int CW  = 16,
  parameter int LW  = $clog2(LEN+1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [LW-1:0] len_i,
  input  logic [LW-1:0] band_i,
  input  logic [AW-1:0] base_i,
  output logic          busy_o,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] data_i,
  output logic          CS_o,
  input  logic [DW-1:0] Sin_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [CW-1:0] res_o,
  output logic          res_err_o,
  output logic          res_valid_o,
  input  logic          res_ready_i
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] INF = '1;

  typedef enum logic [1:0] {IDLE, WAIT_Q, ROW, DONE} state_t;

  state_t         r_state, w_next;
  logic [LW-1:0]  r_len, r_band, r_i, r_k;
  logic [AW-1:0]  r_base;
  logic [DW-1:0]  r_q;
  logic [CW-1:0]  r_left, r_old, r_res;
  logic           r_err;
  logic [CW-1:0]  r_rowbuf [LEN];

  logic           w_bad_len, w_cell, w_last_row, w_row_end;
  logic [LW-1:0]  w_j, w_dist;
  logic           w_inband;
  logic [DW-1:0]  w_ad;
  logic [CW-1:0]  w_up_mem, w_up, w_lf, w_dg, w_min, w_d;
  logic [CW:0]    w_sum;

  assign w_bad_len  = (len_i == '0) || (len_i > LW'(LEN));
  assign w_cell     = (r_state == ROW) && (r_k != '0);
  assign w_row_end  = (r_state == ROW) && (r_k == r_len);
  assign w_last_row = (r_i == r_len - LW'(1));

  // Cell (i, j) is evaluated while the column counter is one ahead of j,
  // because the template word for column j arrives one cycle after its read.
  assign w_j      = r_k - LW'(1);
  assign w_dist   = (r_i >= w_j) ? (r_i - w_j) : (w_j - r_i);
  assign w_inband = (w_dist <= r_band);
  assign w_ad     = (r_q >= data_i) ? (r_q - data_i) : (data_i - r_q);
  assign w_up_mem = r_rowbuf[w_j[IW-1:0]];

  // Neighbour terms; row 0 has no row above, and D(0,0) starts from zero.
  always_comb begin
    w_up = w_up_mem;
    w_lf = r_left;
    w_dg = r_old;
    if (w_j == '0) begin
      w_lf = INF;
      w_dg = INF;
    end
    if (r_i == '0) begin
      w_up = INF;
      w_dg = (w_j == '0) ? '0 : INF;
    end
  end

  // Min of three neighbours, then a saturating add of the local cost.
  always_comb begin
    w_min = w_up;
    if (w_lf < w_min) w_min = w_lf;
    if (w_dg < w_min) w_min = w_dg;
    w_sum = {1'b0, CW'(w_ad)} + {1'b0, w_min};
    if (!w_inband || (w_sum >= {1'b0, INF}))
      w_d = INF;
    else
      w_d = w_sum[CW-1:0];
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake/memory outputs.
  always_comb begin
    w_next      = r_state;
    ready_o     = 1'b0;
    CS_o        = 1'b0;
    busy_o      = 1'b1;
    res_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = w_bad_len ? DONE : WAIT_Q;
      end
      WAIT_Q: begin
        ready_o = 1'b1;
        if (valid_i) w_next = ROW;
      end
      ROW: begin
        CS_o = (r_k < r_len);
        if (w_row_end) w_next = w_last_row ? DONE : WAIT_Q;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign addr_o    = CS_o ? (r_base + AW'(r_k)) : '0;
  assign res_o     = r_res;
  assign res_err_o = r_err;

  // Job parameters, row/column counters, carried cells and the result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len  <= '0;
      r_band <= '0;
      r_base <= '0;
      r_i    <= '0;
      r_k    <= '0;
      r_q    <= '0;
      r_left <= '0;
      r_old  <= '0;
      r_res  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_len  <= len_i;
          r_band <= band_i;
          r_base <= base_i;
          r_i    <= '0;
          if (w_bad_len) begin
            r_res <= INF;
            r_err <= 1'b1;
          end else begin
            r_err <= 1'b0;
          end
        end
        WAIT_Q: if (valid_i) begin
          r_q <= Sin_i;
          r_k <= '0;
        end
        ROW: begin
          r_k <= r_k + LW'(1);
          if (w_cell) begin
            r_left <= w_d;
            r_old  <= w_up_mem;
          end
          if (w_row_end) begin
            if (w_last_row) r_res <= w_d;
            else            r_i   <= r_i + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Row buffer: overwritten in place; each job initialises it in row 0.
  always_ff @(posedge clk_i) begin
    if (w_cell) r_rowbuf[w_j[IW-1:0]] <= w_d;
  end

endmodule

// File: tb/tb_dtw_band_core.sv
// Self-checking bench for dtw_band_core: directed cases plus random jobs,
// compared against a full-matrix DTW model. A second instance with an
// 8-bit cost width shares all inputs to exercise saturation.
module tb_dtw_band_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [5:0] len_i = '0, band_i = '0;
  logic [9:0] base_i = '0;
  logic [7:0] data_i = '0, Sin_i = '0;
  logic       valid_i = 1'b0, res_ready_i = 1'b0;

  logic        busy16, cs16, rdy16, err16, rv16;
  logic [9:0]  addr16;
  logic [15:0] res16;
  logic        busy8, cs8, rdy8, err8, rv8;
  logic [9:0]  addr8;
  logic [7:0]  res8;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [1024];
  logic [9:0] cs_log [$];
  int qa [32];
  int ta [32];

  always #5 clk = ~clk;

  dtw_band_core #(.CW(16)) u16 (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .len_i(len_i), .band_i(band_i),
    .base_i(base_i), .busy_o(busy16), .addr_o(addr16), .data_i(data_i), .CS_o(cs16),
    .Sin_i(Sin_i), .valid_i(valid_i), .ready_o(rdy16), .res_o(res16),
    .res_err_o(err16), .res_valid_o(rv16), .res_ready_i(res_ready_i));

  dtw_band_core #(.CW(8)) u8 (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .len_i(len_i), .band_i(band_i),
    .base_i(base_i), .busy_o(busy8), .addr_o(addr8), .data_i(data_i), .CS_o(cs8),
    .Sin_i(Sin_i), .valid_i(valid_i), .ready_o(rdy8), .res_o(res8),
    .res_err_o(err8), .res_valid_o(rv8), .res_ready_i(res_ready_i));

  // Template SRAM: one-cycle read latency.
  always @(posedge clk) if (cs16) data_i <= mem[addr16];

  // Log of every template read address.
  always @(posedge clk) if (cs16) cs_log.push_back(addr16);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Textbook banded DTW over the full matrix with saturating adds.
  function automatic longint ref_dtw(int L, int W, int cw);
    longint inf = (longint'(1) << cw) - 1;
    longint D [32][32];
    longint c, m, up, lf, dg, s;
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        if (((i > j) ? i - j : j - i) > W) D[i][j] = inf;
        else begin
          c = (qa[i] > ta[j]) ? qa[i] - ta[j] : ta[j] - qa[i];
          if (i == 0 && j == 0) m = 0;
          else begin
            up = (i > 0) ? D[i-1][j] : inf;
            lf = (j > 0) ? D[i][j-1] : inf;
            dg = (i > 0 && j > 0) ? D[i-1][j-1] : inf;
            m = up;
            if (lf < m) m = lf;
            if (dg < m) m = dg;
          end
          s = c + m;
          D[i][j] = (s >= inf) ? inf : s;
        end
      end
    return D[L-1][L-1];
  endfunction

  task automatic run_job(input string tag, input int L, input int W, input int base,
                         input int gap, input int hold, input int exp16, input int exp8);
    int n0, to, badaddr;
    bit inv;
    logic [15:0] r0;
    inv = (L == 0) || (L > 32);
    if (!inv)
      for (int j = 0; j < L; j++) mem[(base + j) % 1024] = 8'(ta[j]);
    n0 = cs_log.size();
    @(negedge clk);
    len_i = 6'(L); band_i = 6'(W); base_i = 10'(base); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    if (inv) chk({tag, "_done_next"}, 32'(rv16), 32'd1);
    else
      for (int r = 0; r < L; r++) begin
        repeat (gap) @(negedge clk);
        valid_i = 1'b1; Sin_i = 8'(qa[r]);
        to = 0;
        while (!rdy16 && to < 500) begin @(negedge clk); to++; end
        if (to >= 500) chk({tag, "_ready_timeout"}, 32'(to), 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
      end
    to = 0;
    while (!rv16 && to < 500) begin @(negedge clk); to++; end
    chk({tag, "_res_valid"}, 32'(rv16), 32'd1);
    if (hold > 0) begin
      r0 = res16;
      badaddr = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!rv16 || res16 !== r0) badaddr++;
      end
      chk({tag, "_hold_stable"}, 32'(badaddr), 32'd0);
    end
    chk({tag, "_res16"}, 32'(res16), inv ? 32'd65535 : 32'(ref_dtw(L, W, 16)));
    chk({tag, "_res8"},  32'(res8),  inv ? 32'd255   : 32'(ref_dtw(L, W, 8)));
    chk({tag, "_err"},   32'(err16), 32'(inv));
    if (exp16 >= 0) chk({tag, "_res16_const"}, 32'(res16), 32'(exp16));
    if (exp8 >= 0)  chk({tag, "_res8_const"},  32'(res8),  32'(exp8));
    chk({tag, "_cs_count"}, 32'(cs_log.size() - n0), inv ? 32'd0 : 32'(L * L));
    badaddr = 0;
    for (int n = n0; n < cs_log.size(); n++)
      if (cs_log[n] !== 10'((base + (n - n0) % L) % 1024)) badaddr++;
    chk({tag, "_addr_seq"}, 32'(badaddr), 32'd0);
    // Result handshake; a start pulse in the same cycle must be ignored.
    res_ready_i = 1'b1; start_i = 1'b1; len_i = 6'd3;
    @(negedge clk);
    res_ready_i = 1'b0; start_i = 1'b0;
    chk({tag, "_idle_after"}, {30'd0, rv16, busy16}, 32'd0);
  endtask

  task automatic set_qt(input int q0, input int q1, input int q2,
                        input int t0, input int t1, input int t2);
    qa[0] = q0; qa[1] = q1; qa[2] = q2;
    ta[0] = t0; ta[1] = t1; ta[2] = t2;
  endtask

  initial begin
    int L, W;
    repeat (2) @(negedge clk);
    chk("reset_outs", {22'd0, busy16, cs16, rdy16, err16, rv16, 5'd0} | 32'(addr16) | 32'(res16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    set_qt(1, 2, 3, 1, 2, 3);
    run_job("same",      3, 3, 10, 0, 0, 0, 0);
    run_job("same_gap",  3, 3, 10, 3, 0, 0, 0);
    set_qt(3, 2, 1, 1, 2, 3);
    run_job("rev",       3, 3, 20, 0, 0, 4, 4);
    set_qt(1, 5, 5, 1, 1, 5);
    run_job("band2",     3, 2, 30, 0, 0, 0, 0);
    run_job("band0",     3, 0, 30, 1, 0, 4, 4);
    qa[0] = 200; qa[1] = 200; ta[0] = 0; ta[1] = 0;
    run_job("sat",       2, 2, 40, 0, 0, 400, 255);
    run_job("len0",      0, 0, 50, 0, 5, 65535, 255);
    run_job("len33",    33, 0, 50, 0, 5, 65535, 255);
    set_qt(7, 9, 250, 8, 3, 251);
    run_job("wrap",      3, 1, 1022, 0, 0, -1, -1);

    // Reset in the middle of row 1 aborts the job.
    for (int j = 0; j < 4; j++) begin qa[j] = 10 * j; ta[j] = 5 * j; end
    @(negedge clk);
    len_i = 6'd4; band_i = 6'd4; base_i = 10'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      valid_i = 1'b1; Sin_i = 8'(qa[r]);
      L = 0;
      while (!rdy16 && L < 100) begin @(negedge clk); L++; end
      @(negedge clk);
      valid_i = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_job", {29'd0, busy16, rv16, rdy16}, 32'd0);
    rst = 1'b0;
    run_job("after_rst", 4, 4, 0, 0, 0, -1, -1);

    for (int n = 0; n < 6; n++) begin
      L = $urandom_range(1, 8);
      W = $urandom_range(0, L);
      for (int j = 0; j < L; j++) begin qa[j] = $urandom_range(0, 255); ta[j] = $urandom_range(0, 255); end
      run_job("rand", L, W, $urandom_range(0, 1023), $urandom_range(0, 3), 0, -1, -1);
    end
    for (int j = 0; j < 32; j++) begin qa[j] = $urandom_range(0, 255); ta[j] = $urandom_range(0, 255); end
    run_job("full32", 32, 5, 900, 0, 0, -1, -1);
    run_job("full32u", 32, 31, 3, 1, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
